atm_pin_entry: RTL and testbench

Keypad PIN collection and verification stage directly upstream of the ATM transaction controller. Collects BCD digits while a card is present, compares them against the card's stored PIN, and drives the controller's `pin_correct` input. Counts failed attempts and retains the card once the limit is reached.

---
 rtl/atm_pin_entry.sv | 158 +++++++++++++++
 tb/tb_atm_pin_entry.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/atm_pin_entry.sv
// Keypad PIN collection/verification ahead of the ATM transaction controller.
// Optional inactivity abort in COLLECT is enabled by defining ATM_PIN_TIMEOUT_EN.
module atm_pin_entry #(
   parameter int PIN_DIGITS     = 4,
   parameter int MAX_ATTEMPTS   = 3,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        card_inserted,
   input  logic [15:0] stored_pin,
   input  logic        key_valid,
   input  logic [3:0]  key_digit,
   input  logic        key_enter,
   input  logic        key_clear,
   output logic        pin_correct,
   output logic        pin_fail,
   output logic        card_retained,
   output logic        timeout,
   output logic [2:0]  digit_count
);

   localparam int PW = 4 * PIN_DIGITS;
   localparam logic [2:0] PD3 = 3'(PIN_DIGITS);
   localparam logic [2:0] MA3 = 3'(MAX_ATTEMPTS);

   typedef enum logic [2:0] {
      S_IDLE, S_COLLECT, S_VERIFY, S_PASS, S_FAIL, S_WAIT_REMOVE, S_LOCKED
   } state_t;

   state_t        state;
   logic [PW-1:0] pin_buf;
   logic [PW-1:0] buf_shift;
   logic [PW-1:0] ref_pin;
   logic [2:0]    attempts;
   logic          any_key;
   logic          idle_expire;

   // Newest digit enters the low nibble, so the first digit ends up on top like stored_pin.
   assign buf_shift = (pin_buf << 4) | PW'(key_digit);
   assign ref_pin   = stored_pin[15 -: PW];
   assign any_key   = key_valid | key_enter | key_clear;

`ifdef ATM_PIN_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] idle_cnt;

   // Expiry fires on the idle edge that would bring the count to TIMEOUT_CYCLES.
   assign idle_expire = !any_key && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         idle_cnt <= '0;
      else if (state == S_COLLECT && card_inserted && !any_key)
         idle_cnt <= idle_cnt + TW'(1);
      else
         idle_cnt <= '0;
   end
`else
   assign idle_expire = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= S_IDLE;
         pin_buf       <= '0;
         digit_count   <= '0;
         attempts      <= '0;
         pin_correct   <= 1'b0;
         pin_fail      <= 1'b0;
         card_retained <= 1'b0;
         timeout       <= 1'b0;
      end else begin
         pin_fail <= 1'b0;
         timeout  <= 1'b0;
         case (state)
            S_IDLE: begin
               pin_buf     <= '0;
               digit_count <= '0;
               attempts    <= '0;
               if (card_inserted) state <= S_COLLECT;
            end
            S_COLLECT: begin
               if (!card_inserted) begin
                  state       <= S_IDLE;
                  pin_buf     <= '0;
                  digit_count <= '0;
                  attempts    <= '0;
               end else if (key_clear) begin
                  pin_buf     <= '0;
                  digit_count <= '0;
               end else if (key_enter) begin
                  if (digit_count == PD3) state <= S_VERIFY;
               end else if (key_valid) begin
                  if (key_digit <= 4'd9 && digit_count < PD3) begin
                     pin_buf     <= buf_shift;
                     digit_count <= digit_count + 3'd1;
                  end
               end else if (idle_expire) begin
                  state       <= S_WAIT_REMOVE;
                  pin_buf     <= '0;
                  digit_count <= '0;
                  timeout     <= 1'b1;
               end
            end
            S_VERIFY: begin
               if (!card_inserted) begin
                  state       <= S_IDLE;
                  pin_buf     <= '0;
                  digit_count <= '0;
                  attempts    <= '0;
               end else if (pin_buf == ref_pin) begin
                  state       <= S_PASS;
                  pin_correct <= 1'b1;
               end else begin
                  state       <= S_FAIL;
                  pin_fail    <= 1'b1;
                  attempts    <= attempts + 3'd1;
                  pin_buf     <= '0;
                  digit_count <= '0;
               end
            end
            S_FAIL: begin
               if (!card_inserted) begin
                  state    <= S_IDLE;
                  attempts <= '0;
               end else if (attempts == MA3) begin
                  state         <= S_LOCKED;
                  card_retained <= 1'b1;
               end else begin
                  state <= S_COLLECT;
               end
            end
            S_PASS: begin
               if (!card_inserted) begin
                  state       <= S_IDLE;
                  pin_correct <= 1'b0;
                  pin_buf     <= '0;
                  digit_count <= '0;
                  attempts    <= '0;
               end
            end
            S_WAIT_REMOVE: begin
               if (!card_inserted) state <= S_IDLE;
            end
            S_LOCKED: begin
               card_retained <= 1'b1;
            end
            default: begin
               state         <= S_IDLE;
               pin_correct   <= 1'b0;
               card_retained <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_atm_pin_entry.sv
// Randomized + directed bench for atm_pin_entry; an event-level reference model
// feeds a per-cycle expectation queue that an independent monitor drains.
module tb_atm_pin_entry;

   localparam int PD = 4;
   localparam int MA = 3;
   localparam int TO = 20;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        card_inserted = 1'b0;
   logic [15:0] stored_pin = 16'h1234;
   logic        key_valid = 1'b0;
   logic [3:0]  key_digit = 4'd0;
   logic        key_enter = 1'b0;
   logic        key_clear = 1'b0;
   logic        pin_correct, pin_fail, card_retained, timeout;
   logic [2:0]  digit_count;

   atm_pin_entry #(.PIN_DIGITS(PD), .MAX_ATTEMPTS(MA), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .card_inserted(card_inserted), .stored_pin(stored_pin),
      .key_valid(key_valid), .key_digit(key_digit), .key_enter(key_enter),
      .key_clear(key_clear), .pin_correct(pin_correct), .pin_fail(pin_fail),
      .card_retained(card_retained), .timeout(timeout), .digit_count(digit_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       pc, pf, cr, to;
      logic [2:0] dc;
   } exp_t;

   exp_t expq[$];
   int vectors = 0;
   int miscompares = 0;

   // Reference model: session phase, typed digits, failed attempts, idle run length.
   typedef enum int { M_IDLE, M_COLLECT, M_VERIFY, M_PASS, M_FAIL, M_WAIT, M_LOCK } ph_t;
   ph_t mph = M_IDLE;
   int  mdig[$];
   int  matt = 0;
   int  midle = 0;
   bit  card_lvl = 1'b0;

   task automatic check_out(input string nm, input exp_t e);
      exp_t a;
      a.pc = pin_correct; a.pf = pin_fail; a.cr = card_retained; a.to = timeout;
      a.dc = digit_count;
      vectors++;
      if (a !== e) begin
         miscompares++;
         $display("FAIL %s t=%0t got pc=%b pf=%b cr=%b to=%b dc=%0d want pc=%b pf=%b cr=%b to=%b dc=%0d",
                  nm, $time, a.pc, a.pf, a.cr, a.to, a.dc, e.pc, e.pf, e.cr, e.to, e.dc);
      end
   endtask

   function automatic bit pin_matches();
      for (int i = 0; i < PD; i++)
         if (mdig[i] != int'((stored_pin >> (12 - 4*i)) & 16'hF)) return 1'b0;
      return 1'b1;
   endfunction

   task automatic m_leave();
      mph = M_IDLE; mdig.delete(); matt = 0;
   endtask

   task automatic model_step();
      exp_t e;
      bit   to_p = 1'b0;
      case (mph)
         M_IDLE: begin
            mdig.delete(); matt = 0;
            if (card_inserted) begin mph = M_COLLECT; midle = 0; end
         end
         M_COLLECT: begin
            if (!card_inserted) m_leave();
            else if (key_clear) begin mdig.delete(); midle = 0; end
            else if (key_enter) begin
               midle = 0;
               if (mdig.size() == PD) mph = M_VERIFY;
            end else if (key_valid) begin
               midle = 0;
               if (key_digit <= 4'd9 && mdig.size() < PD) mdig.push_back(int'(key_digit));
            end else begin
`ifdef ATM_PIN_TIMEOUT_EN
               midle++;
               if (midle == TO) begin mph = M_WAIT; mdig.delete(); to_p = 1'b1; end
`endif
            end
         end
         M_VERIFY: begin
            if (!card_inserted) m_leave();
            else if (pin_matches()) mph = M_PASS;
            else begin matt++; mdig.delete(); mph = M_FAIL; end
         end
         M_FAIL: begin
            if (!card_inserted) m_leave();
            else if (matt == MA) mph = M_LOCK;
            else begin mph = M_COLLECT; midle = 0; end
         end
         M_PASS:  if (!card_inserted) m_leave();
         M_WAIT:  if (!card_inserted) mph = M_IDLE;
         default: ;
      endcase
      e.pc = (mph == M_PASS);
      e.pf = (mph == M_FAIL);
      e.cr = (mph == M_LOCK);
      e.to = to_p;
      e.dc = 3'(mdig.size());
      expq.push_back(e);
   endtask

   task automatic drive(input bit card, input bit v, input logic [3:0] d,
                        input bit ent, input bit clr);
      @(negedge clk);
      rst = 1'b1;
      card_lvl = card;
      card_inserted = card; key_valid = v; key_digit = d; key_enter = ent; key_clear = clr;
      model_step();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(card_lvl, 0, 4'd0, 0, 0);
   endtask

   task automatic key(input logic [3:0] d);
      drive(card_lvl, 1, d, 0, 0);
   endtask

   task automatic enter();
      drive(card_lvl, 0, 4'd0, 1, 0);
   endtask

   task automatic card(input bit c);
      drive(c, 0, 4'd0, 0, 0);
   endtask

   task automatic pin4(input logic [15:0] p);
      for (int i = 0; i < 4; i++) key(4'((p >> (12 - 4*i)) & 16'hF));
   endtask

   task automatic do_reset();
      exp_t z;
      @(negedge clk);
      rst = 1'b0;
      card_inserted = card_lvl; key_valid = 0; key_enter = 0; key_clear = 0;
      mph = M_IDLE; mdig.delete(); matt = 0; midle = 0;
      z = '0;
      #1 check_out("async_reset", z);
      expq.push_back(z);
   endtask

   // Monitor: one expectation is consumed per clock, sampled after the edge settles.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (expq.size() > 0) check_out("cycle", expq.pop_front());
      end
   end

   initial begin
      int r;
      logic [3:0] d;
      bit  c;

      do_reset();
      idle(2);

      // Correct PIN: pin_correct two edges after enter, held until card removed.
      card(1);
      pin4(16'h1234);
      enter();
      idle(4);
      card(0);
      idle(2);

      // Three wrong entries lock the card; keys and removal do not unlock.
      card(1);
      for (int k = 0; k < 3; k++) begin
         pin4(16'h1235);
         enter();
         idle(2);
      end
      pin4(16'h1234);
      enter();
      idle(2);
      card(0);
      idle(2);
      do_reset();
      idle(1);

      // Short entry, bad digit, same-cycle clear+enter.
      card(1);
      key(4'd1); key(4'd2); enter(); idle(2);
      key(4'hA); idle(1);
      key(4'd3); key(4'd4);
      drive(1, 0, 4'd0, 1, 1);
      idle(2);
      pin4(16'h1234); key(4'd9); enter(); idle(3);
      card(0); idle(1);

      // Attempts reset by card removal.
      card(1);
      for (int k = 0; k < 2; k++) begin pin4(16'h9999); enter(); idle(2); end
      card(0); idle(1);
      card(1);
      pin4(16'h1234); enter(); idle(3);
      card(0); idle(1);

      // Inactivity: full idle run, then a key one cycle before expiry.
      card(1);
      key(4'd1); idle(TO + 2);
      card(0); idle(1);
      card(1);
      key(4'd1); idle(TO - 1); key(4'd2); idle(5);

      // Asynchronous reset mid-entry.
      card(1);
      key(4'd5); key(4'd6); key(4'd7);
      do_reset();
      idle(3);

      // Randomized session traffic.
      for (int n = 0; n < 3000; n++) begin
         r = $urandom_range(0, 999);
         if (r < 3) begin
            do_reset();
            for (int i = 0; i < 4; i++) stored_pin[15 - 4*i -: 4] = 4'($urandom_range(0, 9));
         end else if (r < 20) begin
            idle(TO + 3);
         end else begin
            c = card_lvl;
            if ($urandom_range(0, 99) < 3) c = !c;
            if ($urandom_range(0, 99) < 70 && mdig.size() < PD)
               d = 4'((stored_pin >> (12 - 4*mdig.size())) & 16'hF);
            else
               d = 4'($urandom_range(0, 11));
            drive(c, $urandom_range(0, 99) < 45, d,
                  $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 4);
         end
      end

      idle(3);
      repeat (3) @(posedge clk);
      #3;
      vectors++;
      if (expq.size() != 0) begin
         miscompares++;
         $display("FAIL drain got %0d pending want 0", expq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
